// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS instruction/data memory arbiter: FSM states,
// grant identities and the round-robin tie-break helper.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // On a tie the requester that did not win last time is chosen.
  function automatic grant_e pick_grant(input logic i_req, input logic d_req, input grant_e last);
    grant_e g;
    if (i_req && d_req) begin
      g = (last == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      g = GRANT_D;
    end else begin
      g = GRANT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one Avalon-style bus,
// one transaction at a time, with registered bus strobes and responses.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter logic [3:0] BYTEEN_INSTR = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_valid,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_valid,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  grant_e      grant_s;
  logic        d_req_s;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] instr_readdata_q, instr_readdata_d;
  logic [31:0] data_readdata_q, data_readdata_d;
  logic        instr_valid_q, instr_valid_d;
  logic        data_valid_q, data_valid_d;

  // Next-state and next-output logic; everything defaults to hold.
  always_comb begin
    d_req_s          = data_read | data_write;
    grant_s          = pick_grant(instr_req, d_req_s, last_grant_q);
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    address_d        = address_q;
    read_d           = read_q;
    write_d          = write_q;
    writedata_d      = writedata_q;
    byteenable_d     = byteenable_q;
    instr_readdata_d = instr_readdata_q;
    data_readdata_d  = data_readdata_q;
    instr_valid_d    = 1'b0;
    data_valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_req || d_req_s) begin
          last_grant_d = grant_s;
          if (grant_s == GRANT_I) begin
            state_d      = BUS_I;
            address_d    = instr_address;
            byteenable_d = BYTEEN_INSTR;
            read_d       = 1'b1;
            write_d      = 1'b0;
          end else begin
            // A simultaneous read+write request is issued as a store.
            state_d      = BUS_D;
            address_d    = data_address;
            writedata_d  = data_writedata;
            byteenable_d = data_byteenable;
            write_d      = data_write;
            read_d       = data_read & ~data_write;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS_I: begin
        if (!waitrequest) begin
          read_d           = 1'b0;
          write_d          = 1'b0;
          instr_readdata_d = readdata;
          instr_valid_d    = 1'b1;
          state_d          = RESP;
        end else begin
          state_d = BUS_I;
        end
      end
      BUS_D: begin
        if (!waitrequest) begin
          if (read_q) begin
            data_readdata_d = readdata;
          end else begin
            data_readdata_d = data_readdata_q;
          end
          read_d       = 1'b0;
          write_d      = 1'b0;
          data_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          state_d = BUS_D;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= GRANT_D;
      address_q        <= 32'h0000_0000;
      read_q           <= 1'b0;
      write_q          <= 1'b0;
      writedata_q      <= 32'h0000_0000;
      byteenable_q     <= 4'b0000;
      instr_readdata_q <= 32'h0000_0000;
      data_readdata_q  <= 32'h0000_0000;
      instr_valid_q    <= 1'b0;
      data_valid_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      address_q        <= address_d;
      read_q           <= read_d;
      write_q          <= write_d;
      writedata_q      <= writedata_d;
      byteenable_q     <= byteenable_d;
      instr_readdata_q <= instr_readdata_d;
      data_readdata_q  <= data_readdata_d;
      instr_valid_q    <= instr_valid_d;
      data_valid_q     <= data_valid_d;
    end
  end

  assign address        = address_q;
  assign read           = read_q;
  assign write          = write_q;
  assign writedata      = writedata_q;
  assign byteenable     = byteenable_q;
  assign instr_readdata = instr_readdata_q;
  assign data_readdata  = data_readdata_q;
  assign instr_valid    = instr_valid_q;
  assign data_valid     = data_valid_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.BYTEEN_INSTR(4'b1111)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_valid(instr_valid),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_valid(data_valid),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_read"},  32'(read), 32'd0);
    check_value({tag, "_write"}, 32'(write), 32'd0);
    check_value({tag, "_addr"},  address, 32'd0);
    check_value({tag, "_wd"},    writedata, 32'd0);
    check_value({tag, "_be"},    32'(byteenable), 32'd0);
    check_value({tag, "_iv"},    32'(instr_valid), 32'd0);
    check_value({tag, "_dv"},    32'(data_valid), 32'd0);
    check_value({tag, "_ird"},   instr_readdata, 32'd0);
    check_value({tag, "_drd"},   data_readdata, 32'd0);
  endtask

  // Reference-model state for the random phase: requester intentions plus
  // where the single outstanding transaction sits on its timeline.
  bit          i_pend, d_pend;
  int          d_kind;          // 0 load, 1 store, 2 read+write (store)
  logic [31:0] i_addr, d_addr, d_wd;
  logic [3:0]  d_be;
  int          phase;           // 0 free, 1 on bus, 2 response cycle
  bit          owner_d, last_d, exp_wr, do_rst;
  logic [31:0] exp_addr, exp_wd, exp_ird, exp_drd;
  logic [3:0]  exp_be;

  initial begin
    reset = 1'b1; instr_req = 1'b0; instr_address = 32'd0;
    data_read = 1'b0; data_write = 1'b0; data_address = 32'd0;
    data_writedata = 32'd0; data_byteenable = 4'd0;
    waitrequest = 1'b0; readdata = 32'd0;
    tick(); tick();
    check_reset_state("rst");
    reset = 1'b0;

    // Single fetch, no stall.
    instr_req = 1'b1; instr_address = 32'hBFC0_0000; readdata = 32'h2402_0005;
    tick();
    check_value("f_read", 32'(read), 32'd1);
    check_value("f_write", 32'(write), 32'd0);
    check_value("f_addr", address, 32'hBFC0_0000);
    check_value("f_be", 32'(byteenable), 32'hF);
    check_value("f_iv0", 32'(instr_valid), 32'd0);
    tick();
    check_value("f_read_drop", 32'(read), 32'd0);
    check_value("f_iv", 32'(instr_valid), 32'd1);
    check_value("f_ird", instr_readdata, 32'h2402_0005);
    instr_req = 1'b0;
    tick();
    check_value("f_iv_pulse", 32'(instr_valid), 32'd0);

    // Store stalled for four cycles.
    data_write = 1'b1; data_address = 32'h0000_1000; data_writedata = 32'hDEAD_BEEF;
    data_byteenable = 4'b0011; waitrequest = 1'b1; readdata = 32'hCAFE_F00D;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_value("s_write", 32'(write), 32'd1);
      check_value("s_read", 32'(read), 32'd0);
      check_value("s_addr", address, 32'h0000_1000);
      check_value("s_wd", writedata, 32'hDEAD_BEEF);
      check_value("s_be", 32'(byteenable), 32'h3);
      check_value("s_dv0", 32'(data_valid), 32'd0);
      if (c == 4) waitrequest = 1'b0;
    end
    tick();
    check_value("s_write_drop", 32'(write), 32'd0);
    check_value("s_dv", 32'(data_valid), 32'd1);
    check_value("s_drd_keep", data_readdata, 32'd0);
    data_write = 1'b0;
    tick();
    check_value("s_dv_pulse", 32'(data_valid), 32'd0);

    // Simultaneous requests: fetch first, then load, next tie fetch again.
    reset = 1'b1; tick(); reset = 1'b0;
    instr_req = 1'b1; instr_address = 32'h0000_0400;
    data_read = 1'b1; data_address = 32'h0000_0800; data_byteenable = 4'hF;
    readdata = 32'h1111_1111;
    tick();
    check_value("t_addr_i", address, 32'h0000_0400);
    check_value("t_read_i", 32'(read), 32'd1);
    tick();
    check_value("t_iv", 32'(instr_valid), 32'd1);
    check_value("t_dv0", 32'(data_valid), 32'd0);
    check_value("t_ird", instr_readdata, 32'h1111_1111);
    instr_req = 1'b0; readdata = 32'h2222_2222;
    tick();
    check_value("t_resp_read", 32'(read), 32'd0);
    tick();
    check_value("t_addr_d", address, 32'h0000_0800);
    check_value("t_read_d", 32'(read), 32'd1);
    tick();
    check_value("t_dv", 32'(data_valid), 32'd1);
    check_value("t_drd", data_readdata, 32'h2222_2222);
    check_value("t_ird_hold", instr_readdata, 32'h1111_1111);
    instr_req = 1'b1; instr_address = 32'h0000_0404;
    tick(); tick();
    check_value("t_tie2_addr", address, 32'h0000_0404);
    tick();
    check_value("t_tie2_iv", 32'(instr_valid), 32'd1);
    instr_req = 1'b0; data_read = 1'b0;

    // Reset during a stalled load.
    reset = 1'b1; tick(); reset = 1'b0;
    data_read = 1'b1; data_address = 32'h0000_0030; waitrequest = 1'b1;
    tick();
    check_value("r_read", 32'(read), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("r_mid");
    reset = 1'b0; data_read = 1'b0; waitrequest = 1'b0;
    tick();
    check_value("r_dv", 32'(data_valid), 32'd0);
    check_value("r_read_after", 32'(read), 32'd0);

    // Read and write together is a store.
    data_read = 1'b1; data_write = 1'b1; data_address = 32'h0000_0020;
    data_writedata = 32'h1234_5678; data_byteenable = 4'hF; readdata = 32'h9999_9999;
    tick();
    check_value("rw_write", 32'(write), 32'd1);
    check_value("rw_read", 32'(read), 32'd0);
    check_value("rw_addr", address, 32'h0000_0020);
    tick();
    check_value("rw_read2", 32'(read), 32'd0);
    check_value("rw_dv", 32'(data_valid), 32'd1);
    check_value("rw_drd", data_readdata, 32'd0);
    data_read = 1'b0; data_write = 1'b0;

    // Randomized traffic.
    reset = 1'b1; tick(); reset = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_kind = 0; phase = 0; owner_d = 1'b0; last_d = 1'b1;
    exp_ird = 32'd0; exp_drd = 32'd0; exp_wr = 1'b0;
    exp_addr = 32'd0; exp_wd = 32'd0; exp_be = 4'd0;
    i_addr = 32'd0; d_addr = 32'd0; d_wd = 32'd0; d_be = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      do_rst      = ($urandom_range(0, 149) == 0);
      reset       = do_rst;
      waitrequest = ($urandom_range(0, 2) == 0);
      readdata    = $urandom;
      instr_req   = i_pend; instr_address = i_addr;
      data_read   = d_pend && (d_kind != 1);
      data_write  = d_pend && (d_kind != 0);
      data_address = d_addr; data_writedata = d_wd; data_byteenable = d_be;

      if (do_rst) begin
        phase = 0; last_d = 1'b1; exp_ird = 32'd0; exp_drd = 32'd0;
      end else if (phase == 0) begin
        if (i_pend || d_pend) begin
          owner_d = (i_pend && d_pend) ? !last_d : d_pend;
          last_d  = owner_d;
          phase   = 1;
          exp_wr  = owner_d && (d_kind != 0);
          exp_addr = owner_d ? d_addr : i_addr;
          exp_be   = owner_d ? d_be : 4'hF;
          exp_wd   = d_wd;
        end
      end else if (phase == 1) begin
        if (!waitrequest) begin
          phase = 2;
          if (!owner_d) exp_ird = readdata;
          else if (!exp_wr) exp_drd = readdata;
        end
      end else begin
        phase = 0;
      end

      tick();
      if (do_rst) check_reset_state("rnd_rst");
      check_value("rnd_read", 32'(read), 32'(phase == 1 && !exp_wr));
      check_value("rnd_write", 32'(write), 32'(phase == 1 && exp_wr));
      if (phase == 1) begin
        check_value("rnd_addr", address, exp_addr);
        check_value("rnd_be", 32'(byteenable), 32'(exp_be));
        if (exp_wr) check_value("rnd_wd", writedata, exp_wd);
      end
      check_value("rnd_iv", 32'(instr_valid), 32'(phase == 2 && !owner_d));
      check_value("rnd_dv", 32'(data_valid), 32'(phase == 2 && owner_d));
      check_value("rnd_ird", instr_readdata, exp_ird);
      check_value("rnd_drd", data_readdata, exp_drd);

      // Requesters react to what they just saw.
      if (do_rst) begin
        i_pend = 1'b0; d_pend = 1'b0;
      end
      if (phase == 2) begin
        if (owner_d) d_pend = 1'b0;
        else i_pend = 1'b0;
      end
      if (phase == 1 && $urandom_range(0, 7) == 0) begin
        if (owner_d) d_pend = 1'b0;
        else i_pend = 1'b0;
      end
      if (!i_pend && !(phase == 1 && !owner_d) && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && !(phase == 1 && owner_d) && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        d_kind = $urandom_range(0, 2);
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wd   = $urandom;
        d_be   = 4'($urandom_range(1, 15));
      end
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
